// File: rtl/rv_pkg.sv
// Shared core definitions: datapath widths, load funct3 encodings
// and the x0 register index.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [REG_AW-1:0] X0 = '0;

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the byte/halfword addressed by the low
// address bits, extends it, and flags funct3 codes that are not loads.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        illegal_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = data_i[7:0];
        case (addr_lo_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        // Halfword and word accesses ignore the sub-size address bits
        half_sel = addr_lo_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            F3_LW:   data_o = data_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU and load results onto the register
// file write port and tracks outstanding destinations for issue.
module wb_unit
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU_VALID,
    output logic              ALU_READY,
    input  logic [4:0]        ALU_RD,
    input  logic [XLEN-1:0]   ALU_RES,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [4:0]        LD_RD,
    input  logic [XLEN-1:0]   LD_DATA,
    input  logic [1:0]        LD_ADDR_LO,
    input  logic [2:0]        LD_FUNCT3,
    input  logic              ISSUE_VALID,
    input  logic [4:0]        ISSUE_RD,
    output logic [4:0]        A3,
    output logic [XLEN-1:0]   WD3,
    output logic              WE,
    output logic              LD_ERR,
    output logic [XLEN-1:0]   PEND
);

    logic [XLEN-1:0] la_data;
    logic            la_illegal;

    load_align u_load_align (
        .data_i    (LD_DATA),
        .addr_lo_i (LD_ADDR_LO),
        .funct3_i  (LD_FUNCT3),
        .data_o    (la_data),
        .illegal_o (la_illegal)
    );

    logic            owed_q, owed_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] pend_q, pend_d;

    logic            alu_xfer, ld_xfer, xfer;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_res;
    logic            sel_legal;

    // Load has priority unless the ALU was already turned away
    assign LD_READY  = !RST && !(ALU_VALID && owed_q);
    assign ALU_READY = !RST && (!LD_VALID || owed_q);

    assign alu_xfer = ALU_VALID && ALU_READY;
    assign ld_xfer  = LD_VALID && LD_READY;
    assign xfer     = alu_xfer || ld_xfer;

    always_comb begin
        sel_rd    = ALU_RD;
        sel_res   = ALU_RES;
        sel_legal = 1'b1;
        if (ld_xfer) begin
            sel_rd    = LD_RD;
            sel_res   = la_data;
            sel_legal = !la_illegal;
        end
    end

    always_comb begin
        owed_d = owed_q;
        if (alu_xfer)
            owed_d = 1'b0;
        else if (ALU_VALID && !ALU_READY)
            owed_d = 1'b1;

        a3_d  = a3_q;
        wd3_d = wd3_q;
        we_d  = 1'b0;
        err_d = ld_xfer && la_illegal;
        if (xfer) begin
            a3_d  = sel_rd;
            wd3_d = sel_res;
            we_d  = sel_legal && (sel_rd != X0);
        end

        // Clear before set so a same-cycle reissue stays pending
        pend_d = pend_q;
        if (xfer)
            pend_d[sel_rd] = 1'b0;
        if (ISSUE_VALID && ISSUE_RD != X0)
            pend_d[ISSUE_RD] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owed_q <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            owed_q <= owed_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            we_q   <= we_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    // A write already registered when reset rises must not reach the file
    assign A3     = a3_q;
    assign WD3    = wd3_q;
    assign WE     = we_q && !RST;
    assign LD_ERR = err_q && !RST;
    assign PEND   = pend_q;

endmodule
